// File: rtl/branch_resolver.sv
// branch_resolver
// Consumer side of a 2-bit saturating branch predictor. Each fetched branch
// reserves a slot in an in-order FIFO and sends a one-cycle request to the
// predictor. The prediction comes back two edges later and is captured into
// the slot. When execute resolves the oldest captured branch, the actual
// direction is sent back to the predictor and mispredicts are flagged. A
// mispredict flushes every younger in-flight branch.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   branch_valid      fetch offers a branch (accepted when branch_ready)
//   branch_ready      occupancy below DEPTH
//   pred_request      one-cycle pulse to the predictor per accepted branch
//   pred_in           prediction from the predictor (1 = taken)
//   outcome_valid     execute resolves the oldest branch
//   outcome_taken     actual direction
//   upd_result        one-cycle update pulse to the predictor
//   upd_taken         actual direction for the update
//   mispredict        one-cycle pulse when direction != stored prediction
//   head_pred         stored prediction of oldest captured entry (0 if none)
//   occupancy         reserved entries, including those awaiting capture
//   branch_count      resolved branches, saturating
//   miss_count        mispredicts, saturating
//   underflow_err     sticky: outcome arrived with no captured head entry
module branch_resolver #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     branch_valid,
   output logic                     branch_ready,
   output logic                     pred_request,
   input  logic                     pred_in,
   input  logic                     outcome_valid,
   input  logic                     outcome_taken,
   output logic                     upd_result,
   output logic                     upd_taken,
   output logic                     mispredict,
   output logic                     head_pred,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [CNT_W-1:0]         branch_count,
   output logic [CNT_W-1:0]         miss_count,
   output logic                     underflow_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;

   logic [DEPTH-1:0] pred_mem;
   logic [DEPTH-1:0] cap_bits;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    s1_idx;
   logic             s2_valid;
   logic [AW-1:0]    s2_idx;

   logic accept;
   logic head_captured;
   logic resolve;
   logic miss;

   // Handshake and resolve decode. Pointers alone cannot tell full from
   // empty, so the head is only trusted when occupancy is non-zero.
   always_comb begin
      branch_ready  = (occupancy < OW'(DEPTH));
      accept        = branch_valid && branch_ready;
      head_captured = (occupancy != '0) && cap_bits[rd_ptr];
      resolve       = outcome_valid && head_captured;
      miss          = resolve && (outcome_taken != pred_mem[rd_ptr]);
      head_pred     = head_captured && pred_mem[rd_ptr];
   end

   // Request/capture pipeline, FIFO pointers, update pulses and counters.
   // The request register doubles as the first capture stage (its slot index
   // travels in s1_idx); s2 holds the slot whose prediction is on pred_in.
   // A mispredict kills both stages so stale predictions never land, but a
   // branch accepted in that same cycle still starts its own request.
   always_ff @(posedge clk) begin
      if (rst) begin
         pred_mem      <= '0;
         cap_bits      <= '0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         s1_idx        <= '0;
         s2_valid      <= 1'b0;
         s2_idx        <= '0;
         pred_request  <= 1'b0;
         upd_result    <= 1'b0;
         upd_taken     <= 1'b0;
         mispredict    <= 1'b0;
         occupancy     <= '0;
         branch_count  <= '0;
         miss_count    <= '0;
         underflow_err <= 1'b0;
      end else begin
         pred_request <= accept;
         s1_idx       <= wr_ptr;
         s2_valid     <= pred_request && !miss;
         s2_idx       <= s1_idx;

         upd_result <= resolve;
         upd_taken  <= resolve && outcome_taken;
         mispredict <= miss;

         if (outcome_valid && !head_captured)
            underflow_err <= 1'b1;

         if (resolve && (branch_count != {CNT_W{1'b1}}))
            branch_count <= branch_count + CNT_W'(1);
         if (miss && (miss_count != {CNT_W{1'b1}}))
            miss_count <= miss_count + CNT_W'(1);

         if (s2_valid && !miss) begin
            pred_mem[s2_idx] <= pred_in;
            cap_bits[s2_idx] <= 1'b1;
         end

         if (resolve) begin
            cap_bits[rd_ptr] <= 1'b0;
            rd_ptr           <= rd_ptr + AW'(1);
         end

         if (accept) begin
            cap_bits[wr_ptr] <= 1'b0;
            wr_ptr           <= wr_ptr + AW'(1);
         end

         // On a flush the head jumps to the current write slot, which is
         // exactly where a same-cycle accept lands.
         if (miss) begin
            cap_bits  <= '0;
            rd_ptr    <= wr_ptr;
            occupancy <= OW'(accept);
         end else begin
            occupancy <= occupancy + OW'(accept) - OW'(resolve);
         end
      end
   end

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver
// Directed bench for branch_resolver. Two instances share the same inputs:
// dut uses the default counter width, dut_sat uses CNT_W=2 so counter
// saturation can be observed. A small responder returns the next queued
// prediction on pred_in in the cycle after each pred_request.
module tb_branch_resolver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       branch_valid = 1'b0;
   logic       pred_in = 1'b0;
   logic       outcome_valid = 1'b0;
   logic       outcome_taken = 1'b0;

   logic       branch_ready, pred_request, upd_result, upd_taken;
   logic       mispredict, head_pred, underflow_err;
   logic [2:0] occupancy;
   logic [15:0] branch_count, miss_count;

   logic       s_branch_ready, s_pred_request, s_upd_result, s_upd_taken;
   logic       s_mispredict, s_head_pred, s_underflow_err;
   logic [2:0] s_occupancy;
   logic [1:0] s_branch_count, s_miss_count;

   int checks = 0;
   int errors = 0;
   int pulses;
   bit pred_q[$];

   always #5 clk = ~clk;

   branch_resolver #(.DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .branch_valid(branch_valid),
      .branch_ready(branch_ready), .pred_request(pred_request),
      .pred_in(pred_in), .outcome_valid(outcome_valid),
      .outcome_taken(outcome_taken), .upd_result(upd_result),
      .upd_taken(upd_taken), .mispredict(mispredict), .head_pred(head_pred),
      .occupancy(occupancy), .branch_count(branch_count),
      .miss_count(miss_count), .underflow_err(underflow_err)
   );

   branch_resolver #(.DEPTH(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .branch_valid(branch_valid),
      .branch_ready(s_branch_ready), .pred_request(s_pred_request),
      .pred_in(pred_in), .outcome_valid(outcome_valid),
      .outcome_taken(outcome_taken), .upd_result(s_upd_result),
      .upd_taken(s_upd_taken), .mispredict(s_mispredict),
      .head_pred(s_head_pred), .occupancy(s_occupancy),
      .branch_count(s_branch_count), .miss_count(s_miss_count),
      .underflow_err(s_underflow_err)
   );

   // Predictor responder: a request seen in one cycle is answered on
   // pred_in during the following cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (pred_request) begin
            @(posedge clk);
            #1;
            pred_in = (pred_q.size() > 0) ? pred_q.pop_front() : 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      branch_valid = 1'b0;
      outcome_valid = 1'b0;
      outcome_taken = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      pred_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (branch_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %0b exp 1", branch_ready); end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("[TB] FAIL reset_occ got %0d exp 0", occupancy); end
      checks++; if ({pred_request, upd_result, upd_taken, mispredict, head_pred, underflow_err} !== 6'b0) begin errors++; $display("[TB] FAIL reset_flags got %b exp 000000", {pred_request, upd_result, upd_taken, mispredict, head_pred, underflow_err}); end
      checks++; if (branch_count !== 16'd0 || miss_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_counts got %0d/%0d exp 0/0", branch_count, miss_count); end
   endtask

   task automatic test_single();
      do_reset();
      pred_q.push_back(1'b1);
      branch_valid = 1'b1;
      tick();
      branch_valid = 1'b0;
      checks++; if (pred_request !== 1'b1) begin errors++; $display("[TB] FAIL single_req got %0b exp 1", pred_request); end
      checks++; if (occupancy !== 3'd1) begin errors++; $display("[TB] FAIL single_occ got %0d exp 1", occupancy); end
      tick();
      checks++; if (pred_request !== 1'b0) begin errors++; $display("[TB] FAIL single_req_pulse got %0b exp 0", pred_request); end
      checks++; if (head_pred !== 1'b0) begin errors++; $display("[TB] FAIL single_precap_head got %0b exp 0", head_pred); end
      tick();
      checks++; if (head_pred !== 1'b1) begin errors++; $display("[TB] FAIL single_head got %0b exp 1", head_pred); end
      outcome_valid = 1'b1;
      outcome_taken = 1'b1;
      tick();
      outcome_valid = 1'b0;
      checks++; if (upd_result !== 1'b1 || upd_taken !== 1'b1) begin errors++; $display("[TB] FAIL single_upd got %0b%0b exp 11", upd_result, upd_taken); end
      checks++; if (mispredict !== 1'b0) begin errors++; $display("[TB] FAIL single_miss got %0b exp 0", mispredict); end
      checks++; if (branch_count !== 16'd1 || miss_count !== 16'd0) begin errors++; $display("[TB] FAIL single_counts got %0d/%0d exp 1/0", branch_count, miss_count); end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("[TB] FAIL single_occ_end got %0d exp 0", occupancy); end
      tick();
      checks++; if (upd_result !== 1'b0) begin errors++; $display("[TB] FAIL single_upd_pulse got %0b exp 0", upd_result); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < 4; i++) pred_q.push_back(1'b1);
      branch_valid = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks++; if (occupancy !== 3'd4) begin errors++; $display("[TB] FAIL fill_occ got %0d exp 4", occupancy); end
      checks++; if (branch_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_ready got %0b exp 0", branch_ready); end
      tick();
      branch_valid = 1'b0;
      checks++; if (occupancy !== 3'd4) begin errors++; $display("[TB] FAIL fill_fifth got %0d exp 4", occupancy); end
      tick();
      outcome_valid = 1'b1;
      outcome_taken = 1'b1;
      tick();
      checks++; if (branch_ready !== 1'b1 || occupancy !== 3'd3) begin errors++; $display("[TB] FAIL fill_pop got ready %0b occ %0d exp 1/3", branch_ready, occupancy); end
      checks++; if (upd_result !== 1'b1 || mispredict !== 1'b0) begin errors++; $display("[TB] FAIL fill_upd got %0b%0b exp 10", upd_result, mispredict); end
      for (int i = 0; i < 3; i++) tick();
      outcome_valid = 1'b0;
      checks++; if (occupancy !== 3'd0 || branch_count !== 16'd4) begin errors++; $display("[TB] FAIL fill_drain got occ %0d cnt %0d exp 0/4", occupancy, branch_count); end
      checks++; if (underflow_err !== 1'b0) begin errors++; $display("[TB] FAIL fill_underflow got %0b exp 0", underflow_err); end
   endtask

   task automatic test_mispredict();
      do_reset();
      pred_q.push_back(1'b1);
      pred_q.push_back(1'b1);
      pred_q.push_back(1'b0);
      branch_valid = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      branch_valid = 1'b0;
      tick();
      tick();
      checks++; if (head_pred !== 1'b1 || occupancy !== 3'd3) begin errors++; $display("[TB] FAIL mis_pre got head %0b occ %0d exp 1/3", head_pred, occupancy); end
      outcome_valid = 1'b1;
      outcome_taken = 1'b0;
      tick();
      outcome_valid = 1'b0;
      checks++; if (mispredict !== 1'b1 || upd_result !== 1'b1 || upd_taken !== 1'b0) begin errors++; $display("[TB] FAIL mis_pulse got %0b%0b%0b exp 110", mispredict, upd_result, upd_taken); end
      checks++; if (miss_count !== 16'd1 || branch_count !== 16'd1) begin errors++; $display("[TB] FAIL mis_counts got %0d/%0d exp 1/1", branch_count, miss_count); end
      checks++; if (occupancy !== 3'd0 || head_pred !== 1'b0) begin errors++; $display("[TB] FAIL mis_flush got occ %0d head %0b exp 0/0", occupancy, head_pred); end
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (upd_result === 1'b1) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL mis_no_more_upd got %0d exp 0", pulses); end
   endtask

   task automatic test_flush_accept();
      do_reset();
      pred_q.push_back(1'b1);
      pred_q.push_back(1'b1);
      branch_valid = 1'b1;
      tick();
      tick();
      branch_valid = 1'b0;
      tick();
      tick();
      pred_q.push_back(1'b1);
      outcome_valid = 1'b1;
      outcome_taken = 1'b0;
      branch_valid = 1'b1;
      tick();
      outcome_valid = 1'b0;
      branch_valid = 1'b0;
      checks++; if (mispredict !== 1'b1 || occupancy !== 3'd1) begin errors++; $display("[TB] FAIL fa_flush got mis %0b occ %0d exp 1/1", mispredict, occupancy); end
      checks++; if (pred_request !== 1'b1) begin errors++; $display("[TB] FAIL fa_req got %0b exp 1", pred_request); end
      tick();
      tick();
      checks++; if (head_pred !== 1'b1) begin errors++; $display("[TB] FAIL fa_head got %0b exp 1", head_pred); end
      outcome_valid = 1'b1;
      outcome_taken = 1'b1;
      tick();
      outcome_valid = 1'b0;
      checks++; if (upd_result !== 1'b1 || mispredict !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("[TB] FAIL fa_resolve got upd %0b mis %0b occ %0d exp 1/0/0", upd_result, mispredict, occupancy); end
      checks++; if (branch_count !== 16'd2 || miss_count !== 16'd1) begin errors++; $display("[TB] FAIL fa_counts got %0d/%0d exp 2/1", branch_count, miss_count); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      pred_q.push_back(1'b1);
      pred_q.push_back(1'b0);
      branch_valid = 1'b1;
      tick();
      branch_valid = 1'b0;
      tick();
      tick();
      branch_valid = 1'b1;
      outcome_valid = 1'b1;
      outcome_taken = 1'b1;
      tick();
      branch_valid = 1'b0;
      outcome_valid = 1'b0;
      checks++; if (occupancy !== 3'd1 || pred_request !== 1'b1) begin errors++; $display("[TB] FAIL b2b_occ got occ %0d req %0b exp 1/1", occupancy, pred_request); end
      checks++; if (upd_result !== 1'b1 || mispredict !== 1'b0) begin errors++; $display("[TB] FAIL b2b_upd got %0b%0b exp 10", upd_result, mispredict); end
      tick();
      tick();
      checks++; if (head_pred !== 1'b0 || occupancy !== 3'd1) begin errors++; $display("[TB] FAIL b2b_head got head %0b occ %0d exp 0/1", head_pred, occupancy); end
      outcome_valid = 1'b1;
      outcome_taken = 1'b0;
      tick();
      outcome_valid = 1'b0;
      checks++; if (upd_result !== 1'b1 || upd_taken !== 1'b0 || mispredict !== 1'b0) begin errors++; $display("[TB] FAIL b2b_second got %0b%0b%0b exp 100", upd_result, upd_taken, mispredict); end
      checks++; if (occupancy !== 3'd0 || branch_count !== 16'd2) begin errors++; $display("[TB] FAIL b2b_end got occ %0d cnt %0d exp 0/2", occupancy, branch_count); end
   endtask

   task automatic test_underflow();
      do_reset();
      pred_q.push_back(1'b1);
      branch_valid = 1'b1;
      tick();
      branch_valid = 1'b0;
      outcome_valid = 1'b1;
      outcome_taken = 1'b1;
      tick();
      outcome_valid = 1'b0;
      checks++; if (upd_result !== 1'b0 || underflow_err !== 1'b1) begin errors++; $display("[TB] FAIL uf_flag got upd %0b err %0b exp 0/1", upd_result, underflow_err); end
      checks++; if (occupancy !== 3'd1 || branch_count !== 16'd0) begin errors++; $display("[TB] FAIL uf_state got occ %0d cnt %0d exp 1/0", occupancy, branch_count); end
      tick();
      outcome_valid = 1'b1;
      tick();
      outcome_valid = 1'b0;
      checks++; if (upd_result !== 1'b1 || underflow_err !== 1'b1) begin errors++; $display("[TB] FAIL uf_sticky got upd %0b err %0b exp 1/1", upd_result, underflow_err); end
      do_reset();
      checks++; if (underflow_err !== 1'b0) begin errors++; $display("[TB] FAIL uf_clear got %0b exp 0", underflow_err); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         pred_q.push_back(1'b1);
         branch_valid = 1'b1;
         tick();
         branch_valid = 1'b0;
         tick();
         tick();
         outcome_valid = 1'b1;
         outcome_taken = 1'b0;
         tick();
         outcome_valid = 1'b0;
         checks++; if (s_mispredict !== 1'b1) begin errors++; $display("[TB] FAIL sat_miss_%0d got %0b exp 1", i, s_mispredict); end
      end
      checks++; if (s_branch_count !== 2'd3 || s_miss_count !== 2'd3) begin errors++; $display("[TB] FAIL sat_counts got %0d/%0d exp 3/3", s_branch_count, s_miss_count); end
      checks++; if (branch_count !== 16'd5 || miss_count !== 16'd5) begin errors++; $display("[TB] FAIL wide_counts got %0d/%0d exp 5/5", branch_count, miss_count); end
      pred_q.push_back(1'b1);
      pred_q.push_back(1'b1);
      branch_valid = 1'b1;
      tick();
      tick();
      branch_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pred_q.delete();
      checks++; if (occupancy !== 3'd0 || branch_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_occ got occ %0d ready %0b exp 0/1", occupancy, branch_ready); end
      checks++; if ({pred_request, upd_result, mispredict, head_pred, s_branch_count, s_miss_count} !== 8'b0) begin errors++; $display("[TB] FAIL mid_reset_outs got %b exp 00000000", {pred_request, upd_result, mispredict, head_pred, s_branch_count, s_miss_count}); end
      tick();
      tick();
      checks++; if (pred_request !== 1'b0 || head_pred !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("[TB] FAIL mid_reset_cancel got req %0b head %0b occ %0d exp 0/0/0", pred_request, head_pred, occupancy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_mispredict();
      test_flush_accept();
      test_back_to_back();
      test_underflow();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
